// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory and its byte-stream loader.
// Byte lane k of a 64-bit word holds the byte at address offset k, matching
// the fetch byte-swap, so instructions land MSB-first in address order.
package imem_loader_pkg;

  localparam int WORD_BYTES = 8;
  localparam int LANE_W     = 3;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;

  // Lane 0 (lowest address) occupies the least-significant byte of the word.
  localparam int LANE0_LSB   = 0;
  localparam int LANE_STRIDE = BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;

  // Bit position of the least-significant bit of a byte lane.
  function automatic int lane_lsb(input logic [LANE_W-1:0] lane);
    return LANE0_LSB + LANE_STRIDE * int'(lane);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-organised storage: byte-enable synchronous write, combinational read.
// Contents are deliberately not reset so a reset never erases loaded code.
module imem_array
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_BYTES-1:0] wr_be,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_W-1:0]     rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WORD_W-1:0] mem [DEPTH];

  // Byte-masked write; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (wr_be[k]) begin
          mem[wr_addr][k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Zero-latency read; a read of the word being written sees the old value.
  assign rd_data = rd_en ? mem[rd_addr] : '0;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory responder plus byte-stream loader that packs bytes
// into 64-bit words and writes them with byte enables.
//
// state | meaning
// IDLE  | waiting for ld_start; byte stream ignored
// LOAD  | accepting bytes into the pack buffer
// FLUSH | one cycle writing the packed word, ld_ready low
// DONE  | one-cycle ld_done pulse, then back to IDLE
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_re,
  output logic [63:0]           mem_rdata,
  input  logic                  ld_start,
  input  logic [ADDR_WIDTH-1:0] ld_base,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  ld_busy,
  output logic                  ld_done,
  output logic [ADDR_WIDTH:0]   ld_words
);

  localparam logic [ADDR_WIDTH:0] WORDS_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  ld_state_e             state;
  ld_state_e             state_nxt;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [LANE_W-1:0]     lane;
  logic [WORD_BYTES-1:0] be;
  logic [WORD_W-1:0]     pbuf;
  logic                  last_seen;
  logic                  accept;
  logic                  word_end;
  logic                  wr_en;

  assign accept   = ld_valid && ld_ready;
  assign word_end = (lane == LANE_W'(WORD_BYTES - 1)) || ld_last;
  assign wr_en    = (state == ST_FLUSH);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    ld_busy   = 1'b1;
    ld_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        ld_busy = 1'b0;
        if (ld_start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (accept && word_end) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_nxt = last_seen ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        ld_done   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pack buffer, write pointer and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      lane      <= '0;
      be        <= '0;
      pbuf      <= '0;
      last_seen <= 1'b0;
      ld_words  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_start) begin
            wptr      <= ld_base;
            lane      <= '0;
            be        <= '0;
            last_seen <= 1'b0;
            ld_words  <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            pbuf[lane_lsb(lane) +: BYTE_W] <= ld_data;
            be[lane]                       <= 1'b1;
            lane                           <= lane + 1'b1;
            if (word_end) last_seen <= ld_last;
          end
        end
        ST_FLUSH: begin
          wptr <= wptr + 1'b1;
          be   <= '0;
          lane <= '0;
          if (ld_words != WORDS_MAX) ld_words <= ld_words + 1'b1;
        end
        default: ;
      endcase
    end
  end

  imem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wptr),
    .wr_be  (be),
    .wr_data(pbuf),
    .rd_en  (mem_re),
    .rd_addr(mem_addr),
    .rd_data(mem_rdata)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader.
module tb_imem_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [63:0]   mem_rdata;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;
  logic [AW:0]   ld_words;

  int n_vec = 0;
  int n_err = 0;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_addr (mem_addr),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .ld_words (ld_words)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    logic [127:0]  bytes;   // byte i at bits [8i+7:8i]
    logic [AW-1:0] a0;
    logic [63:0]   e0;
    logic [AW-1:0] a1;
    logic [63:0]   e1;
    int            words;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [AW-1:0] a);
    mem_addr = a;
    mem_re   = 1'b1;
    return 64'h0;
  endfunction

  task automatic read_word(input logic [AW-1:0] a, output logic [63:0] d);
    mem_addr = a;
    mem_re   = 1'b1;
    #1;
    d = mem_rdata;
  endtask

  // Drives a full load with ld_valid held high; records the cycles (counted
  // from the first LOAD cycle = 1) where ld_ready was low before ld_done.
  task automatic run_load(input logic [AW-1:0] base, input int n, input logic [127:0] bytes,
                          output logic [31:0] low_mask, output int done_cyc,
                          output logic busy_after);
    int i, c, guard;
    logic rdy;
    low_mask = '0;
    done_cyc = -1;
    @(negedge clk);
    ld_start = 1'b1;
    ld_base  = base;
    @(negedge clk);
    ld_start = 1'b0;
    c = 1;
    i = 0;
    guard = 0;
    while (i < n && guard < 200) begin
      ld_valid = 1'b1;
      ld_data  = bytes[8*i +: 8];
      ld_last  = (i == n - 1);
      rdy = ld_ready;
      if (!rdy && c < 32) low_mask[c] = 1'b1;
      @(negedge clk);
      c++;
      guard++;
      if (rdy) i++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    while (done_cyc < 0 && guard < 200) begin
      if (ld_done) done_cyc = c;
      else if (!ld_ready && c < 32) low_mask[c] = 1'b1;
      @(negedge clk);
      c++;
      guard++;
    end
    busy_after = ld_busy;
  endtask

  initial begin
    logic [31:0] mask, exp_mask;
    logic [63:0] d, old_w, new_w;
    int done_cyc, exp_done, c, acc, guard, dones;
    logic busy_after;

    vt[0] = '{10'd0,    8,  128'h9300100013000000, 10'd0,    64'h9300100013000000,
              10'd0,    64'h9300100013000000, 1};
    vt[1] = '{10'd5,    8,  128'hFFFFFFFFFFFFFFFF, 10'd5,    64'hFFFFFFFFFFFFFFFF,
              10'd5,    64'hFFFFFFFFFFFFFFFF, 1};
    vt[2] = '{10'd5,    3,  128'hCCBBAA,           10'd5,    64'hFFFFFFFFFFCCBBAA,
              10'd0,    64'h9300100013000000, 1};
    vt[3] = '{10'd10,   16, 128'h100F0E0D0C0B0A09_0807060504030201,
              10'd10,   64'h0807060504030201, 10'd11, 64'h100F0E0D0C0B0A09, 2};
    vt[4] = '{10'd1023, 16, 128'h99AABBCCDDEEFF00_1122334455667788,
              10'd1023, 64'h1122334455667788, 10'd0,  64'h99AABBCCDDEEFF00, 2};
    vt[5] = '{10'd3,    8,  128'h0123456789ABCDEF, 10'd3,    64'h0123456789ABCDEF,
              10'd10,   64'h0807060504030201, 1};
    vt[6] = '{10'd20,   8,  128'h1111111111111111, 10'd20,   64'h1111111111111111,
              10'd3,    64'h0123456789ABCDEF, 1};
    vt[7] = '{10'd20,   1,  128'h5A,               10'd20,   64'h111111111111115A,
              10'd5,    64'hFFFFFFFFFFCCBBAA, 1};
    vt[8] = '{10'd7,    9,  128'hD0_C7C6C5C4C3C2C1C0, 10'd7, 64'hC7C6C5C4C3C2C1C0,
              10'd1023, 64'h1122334455667788, 2};

    rst_n    = 1'b0;
    mem_addr = '0;
    mem_re   = 1'b0;
    ld_start = 1'b0;
    ld_base  = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ld_ready", 64'(ld_ready), 64'h0);
    chk("reset ld_busy",  64'(ld_busy),  64'h0);
    chk("reset ld_done",  64'(ld_done),  64'h0);
    chk("reset ld_words", 64'(ld_words), 64'h0);
    chk("reset rdata re=0", mem_rdata, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Byte valid while IDLE must be ignored.
    ld_valid = 1'b1;
    @(negedge clk);
    chk("idle ignores valid busy", 64'(ld_busy), 64'h0);
    ld_valid = 1'b0;

    for (int v = 0; v < 9; v++) begin
      exp_mask = '0;
      c = 0;
      for (int i = 0; i < vt[v].n; i++) begin
        c++;
        if ((i % 8) == 7 || i == vt[v].n - 1) begin
          c++;
          exp_mask[c] = 1'b1;
        end
      end
      exp_done = c + 1;
      run_load(vt[v].base, vt[v].n, vt[v].bytes, mask, done_cyc, busy_after);
      chk($sformatf("v%0d ready_low_cycles", v), 64'(mask), 64'(exp_mask));
      chk($sformatf("v%0d done_cycle", v), 64'(done_cyc), 64'(exp_done));
      chk($sformatf("v%0d busy_after_done", v), 64'(busy_after), 64'h0);
      chk($sformatf("v%0d ld_words", v), 64'(ld_words), 64'(vt[v].words));
      read_word(vt[v].a0, d);
      chk($sformatf("v%0d word0", v), d, vt[v].e0);
      read_word(vt[v].a1, d);
      chk($sformatf("v%0d word1", v), d, vt[v].e1);
      mem_re = 1'b0;
    end

    // Reset after 5 accepted bytes of a load to word 3.
    @(negedge clk);
    ld_start = 1'b1;
    ld_base  = 10'd3;
    @(negedge clk);
    ld_start = 1'b0;
    acc = 0;
    guard = 0;
    while (acc < 5 && guard < 50) begin
      ld_valid = 1'b1;
      ld_data  = 8'hEE;
      ld_last  = 1'b0;
      if (ld_ready) acc++;
      @(negedge clk);
      guard++;
    end
    ld_valid = 1'b0;
    chk("midload accepted", 64'(acc), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("midload rst ld_ready", 64'(ld_ready), 64'h0);
    chk("midload rst ld_busy",  64'(ld_busy),  64'h0);
    chk("midload rst ld_words", 64'(ld_words), 64'h0);
    dones = int'(ld_done);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      dones += int'(ld_done);
    end
    chk("midload no ld_done", 64'(dones), 64'h0);
    chk("midload busy idle", 64'(ld_busy), 64'h0);
    read_word(10'd3, d);
    chk("midload word3 kept", d, 64'h0123456789ABCDEF);
    read_word(10'd10, d);
    chk("midload word10 kept", d, 64'h0807060504030201);
    mem_re = 1'b0;

    // Continuous read of word 7 while it is flushed.
    old_w = 64'hC7C6C5C4C3C2C1C0;
    new_w = 64'h7877767574737271;
    mem_addr = 10'd7;
    mem_re   = 1'b1;
    @(negedge clk);
    ld_start = 1'b1;
    ld_base  = 10'd7;
    @(negedge clk);
    ld_start = 1'b0;
    acc = 0;
    guard = 0;
    while (acc < 8 && guard < 50) begin
      ld_valid = 1'b1;
      ld_data  = new_w[8*acc +: 8];
      ld_last  = (acc == 7);
      chk($sformatf("rdw pre-flush %0d", acc), mem_rdata, old_w);
      if (ld_ready) acc++;
      @(negedge clk);
      guard++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("rdw flush ld_ready", 64'(ld_ready), 64'h0);
    chk("rdw flush old data", mem_rdata, old_w);
    @(negedge clk);
    chk("rdw next new data", mem_rdata, new_w);
    chk("rdw done pulse", 64'(ld_done), 64'h1);
    mem_re = 1'b0;
    #1;
    chk("rdw re=0 zero", mem_rdata, 64'h0);
    @(negedge clk);
    chk("rdw done one cycle", 64'(ld_done), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction/data memory responder on the far side of the fetch memory port.
- Accepts word reads (`mem_addr`, `mem_re`) and returns 64-bit `mem_rdata`.
- Also provides a byte-stream load port (from testbench, UART boot loader or DMA) that packs bytes into 64-bit words and writes them into the array.
- Byte order matches the fetch byte-swap: byte at offset k of a word sits in lane [8k+7:8k], so instructions are stored MSB-first in address order.

Parameters:
- ADDR_WIDTH, 10, word-address width; depth = 2**ADDR_WIDTH 64-bit words.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_addr  in  ADDR_WIDTH  read word address (fetch drives pc[ADDR_WIDTH+2:3]).
- mem_re  in  1  read enable.
- mem_rdata  out  64  read data.
- ld_start  in  1  start-of-load pulse, sampled in IDLE only.
- ld_base  in  ADDR_WIDTH  first word address of the load, sampled with ld_start.
- ld_valid  in  1  byte valid.
- ld_data  in  8  byte, in ascending address order.
- ld_last  in  1  final byte of load, qualified by ld_valid.
- ld_ready  out  1  loader accepts a byte this cycle.
- ld_busy  out  1  high while not IDLE.
- ld_done  out  1  one-cycle pulse at load completion.
- ld_words  out  ADDR_WIDTH+1  words written by current/last load.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; ld_ready=0, ld_busy=0, ld_done=0, ld_words=0.
  - Pack buffer and byte enables cleared.
  - Array contents NOT reset.
- Read path is combinational, zero latency:
  - mem_rdata = mem_re ? mem[mem_addr] : 64'h0.
  - A write lands on the clock edge. A same-cycle read of the word being written returns the old data; the new data is visible the next cycle.
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - ld_ready=0.
  - ld_start=1 -> LOAD; wptr<=ld_base, lane<=0, be<=0, ld_words<=0, last_seen<=0.
  - ld_valid is ignored.
- LOAD:
  - ld_ready=1. A byte is accepted when ld_valid&&ld_ready: buf[lane]<=ld_data, be[lane]<=1, lane<=lane+1.
  - If the accepted byte has lane==7 or ld_last=1 -> FLUSH, and last_seen<=ld_last.
  - ld_start is ignored outside IDLE.
- FLUSH (exactly 1 cycle, ld_ready=0):
  - Write mem[wptr] with byte enables be. Lanes whose be bit is 0 keep their old contents.
  - wptr<=wptr+1, wrapping modulo 2**ADDR_WIDTH.
  - ld_words<=ld_words+1; be<=0; lane<=0.
  - Next state: DONE if last_seen, else LOAD.
- DONE: ld_done=1 for one cycle -> IDLE. ld_words holds its value until the next ld_start.
- ld_busy=1 in LOAD, FLUSH and DONE.
- Throughput: 8 bytes per 9 cycles. ld_ready drops for exactly the FLUSH cycle.
- ld_last on lane 0 gives a single-byte write; the other 7 lanes are preserved.
- ld_words saturates at 2**ADDR_WIDTH; wptr still wraps.
- Reset mid-load:
  - Bytes in the pack buffer are discarded and that word is not written.
  - Words already flushed are retained.
  - Returns to IDLE; ld_done is not pulsed.

Decomposition:
- Shared header rv64_mem_defs.vh:
  - FSM state encodings.
  - WORD_BYTES=8 and LANE_W=3.
  - Byte-lane ordering localparams, shared with fetch and the future data-memory port.
- One sub-module: imem_array. It holds the 2**ADDR_WIDTH x 64 storage, 8-bit byte-enable synchronous write and asynchronous read.
- imem_loader holds the FSM, pack buffer, pointers and counters.

Test Plan:
1. Reset; load base 0, bytes 00 00 00 13 00 10 00 93 (last on 8th), mem_addr=0, mem_re=1 -> mem_rdata=64'h9300100013000000; fetch-side swap gives 0x00000013 (pc 0) and 0x00100093 (pc 4); ld_words=1; ld_done high 1 cycle.
2. Preload word 5 = all-ones; load base 5, bytes AA BB CC, last on CC -> mem[5]=64'hFFFFFFFFFFCCBBAA; ld_ready low in FLUSH; ld_words=1.
3. 16 bytes with ld_valid held high -> ld_ready low exactly on cycles 9 and 18 after LOAD entry; ld_words=2; ld_done on cycle 19; ld_busy low the following cycle.
4. Base 2**ADDR_WIDTH-1 (1023), 16 bytes -> first word at 1023, second at 0; ld_words=2.
5. After 5 accepted bytes of a load to word 3, pulse rst_n low -> mem[3] unchanged, ld_ready=0, ld_busy=0, ld_words=0, no ld_done; earlier-loaded words unchanged.
6. Read word 7 continuously with mem_re=1 while it is flushed -> old value in the FLUSH cycle, new value next cycle; mem_re=0 -> mem_rdata=0.
